// File: rtl/id_stage_pipe_if.sv
// Handshake/bus bundle between the pipeline control (master) and the ID stage (slave).
interface id_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(NREG);

  logic [31:0]      ins_in;
  logic [XLEN-1:0]  pc_in;
  logic             valid_in;
  logic             flush_in;
  logic             ex_valid;
  logic             ex_memtoreg;
  logic [AW-1:0]    ex_rw;
  logic             wb_we;
  logic [AW-1:0]    wb_rw;
  logic [XLEN-1:0]  wb_data;
  logic             stall_out;
  logic             id_valid;
  logic [16:0]      id_ctrl;
  logic [XLEN-1:0]  id_A;
  logic [XLEN-1:0]  id_B;
  logic [XLEN-1:0]  id_ext;
  logic [XLEN-1:0]  id_imm;
  logic [XLEN-1:0]  id_index;
  logic [XLEN-1:0]  id_pc;
  logic [AW-1:0]    id_rw;
  logic [XLEN-1:0]  syscall_out;
  logic [CNT_W-1:0] syscall_count;
  logic             halt;

  modport master (
    output ins_in, pc_in, valid_in, flush_in, ex_valid, ex_memtoreg, ex_rw,
           wb_we, wb_rw, wb_data,
    input  stall_out, id_valid, id_ctrl, id_A, id_B, id_ext, id_imm, id_index,
           id_pc, id_rw, syscall_out, syscall_count, halt
  );

  modport slave (
    input  ins_in, pc_in, valid_in, flush_in, ex_valid, ex_memtoreg, ex_rw,
           wb_we, wb_rw, wb_data,
    output stall_out, id_valid, id_ctrl, id_A, id_B, id_ext, id_imm, id_index,
           id_pc, id_rw, syscall_out, syscall_count, halt
  );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS-subset decode stage: control decode, register file with WB bypass, load-use
// hazard detection, ID/EX register, syscall display/counter and sticky halt FSM.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int BYPASS   = 1,
  parameter int SYS_EXIT = 10,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_stage_pipe_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {RUN, HALTED} state_t;
  state_t state_reg;

  logic [5:0]       op, funct;
  logic [AW-1:0]    rs, rt, rd, ra, rb, rw;
  logic [3:0]       aluop;
  logic             jr, jal, j, bne, beq, blez, memwrite, memtoreg;
  logic             regwrite, alusrc, regdst, lb, lui, syscall;
  logic [1:0]       extop;
  logic [31:0]      ext32;
  logic [16:0]      ctrl;
  logic [XLEN-1:0]  rf_reg [NREG];
  logic [XLEN-1:0]  rd_a, rd_b;
  logic             lu, accept, halt_now, display;

  logic             id_valid_reg, halt_reg;
  logic [16:0]      id_ctrl_reg;
  logic [XLEN-1:0]  a_reg, b_reg, ext_reg, imm_reg, index_reg, pc_reg, sys_out_reg;
  logic [AW-1:0]    rw_reg;
  logic [CNT_W-1:0] count_reg;

  assign op    = bus.ins_in[31:26];
  assign funct = bus.ins_in[5:0];
  assign rs    = AW'(bus.ins_in[25:21]);
  assign rt    = AW'(bus.ins_in[20:16]);
  assign rd    = AW'(bus.ins_in[15:11]);

  always_comb begin
    aluop = 4'd0; jr = 1'b0; jal = 1'b0; j = 1'b0; bne = 1'b0; beq = 1'b0;
    blez = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; regwrite = 1'b0;
    alusrc = 1'b0; regdst = 1'b0; lb = 1'b0; lui = 1'b0; syscall = 1'b0;
    extop = 2'd0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin regwrite = 1'b1; regdst = 1'b1; aluop = 4'd0; end
          6'h22, 6'h23: begin regwrite = 1'b1; regdst = 1'b1; aluop = 4'd1; end
          6'h24: begin regwrite = 1'b1; regdst = 1'b1; aluop = 4'd2; end
          6'h25: begin regwrite = 1'b1; regdst = 1'b1; aluop = 4'd3; end
          6'h26: begin regwrite = 1'b1; regdst = 1'b1; aluop = 4'd4; end
          6'h27: begin regwrite = 1'b1; regdst = 1'b1; aluop = 4'd5; end
          6'h2A: begin regwrite = 1'b1; regdst = 1'b1; aluop = 4'd6; end
          6'h2B: begin regwrite = 1'b1; regdst = 1'b1; aluop = 4'd7; end
          // Shifts take rt as A and the shamt through the extender as B.
          6'h00: begin regwrite = 1'b1; regdst = 1'b1; alusrc = 1'b1; extop = 2'd2; aluop = 4'd8;  end
          6'h02: begin regwrite = 1'b1; regdst = 1'b1; alusrc = 1'b1; extop = 2'd2; aluop = 4'd9;  end
          6'h03: begin regwrite = 1'b1; regdst = 1'b1; alusrc = 1'b1; extop = 2'd2; aluop = 4'd10; end
          6'h08: jr = 1'b1;
          6'h0C: syscall = 1'b1;
          default: ;
        endcase
      end
      6'h08, 6'h09: begin regwrite = 1'b1; alusrc = 1'b1; extop = 2'd1; aluop = 4'd0; end
      6'h0C: begin regwrite = 1'b1; alusrc = 1'b1; aluop = 4'd2; end
      6'h0D: begin regwrite = 1'b1; alusrc = 1'b1; aluop = 4'd3; end
      6'h0E: begin regwrite = 1'b1; alusrc = 1'b1; aluop = 4'd4; end
      6'h0A: begin regwrite = 1'b1; alusrc = 1'b1; extop = 2'd1; aluop = 4'd6; end
      6'h0B: begin regwrite = 1'b1; alusrc = 1'b1; extop = 2'd1; aluop = 4'd7; end
      6'h0F: begin regwrite = 1'b1; lui = 1'b1; end
      6'h23: begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; extop = 2'd1; end
      6'h20: begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; lb = 1'b1; extop = 2'd1; end
      6'h2B: begin memwrite = 1'b1; alusrc = 1'b1; extop = 2'd1; end
      6'h04: begin beq = 1'b1; extop = 2'd1; aluop = 4'd1; end
      6'h05: begin bne = 1'b1; extop = 2'd1; aluop = 4'd1; end
      6'h06: begin blez = 1'b1; extop = 2'd1; aluop = 4'd1; end
      6'h02: j = 1'b1;
      6'h03: begin jal = 1'b1; regwrite = 1'b1; end
      default: ;
    endcase
  end

  assign ctrl = {aluop, jr, jal, j, bne, beq, blez, memwrite, memtoreg,
                 regwrite, alusrc, regdst, lb, lui};

  always_comb begin
    case (extop)
      2'd1:    ext32 = {{16{bus.ins_in[15]}}, bus.ins_in[15:0]};
      2'd2:    ext32 = {27'd0, bus.ins_in[10:6]};
      default: ext32 = {16'd0, bus.ins_in[15:0]};
    endcase
  end

  // Syscall reads $v0 (service) into A and $a0 (argument) into B.
  assign ra = syscall ? AW'(2) : ((extop == 2'd2) ? rt : rs);
  assign rb = syscall ? AW'(4) : rt;
  assign rw = jal ? AW'(31) : (regdst ? rd : rt);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else if (bus.wb_we && bus.wb_rw != '0) begin
      rf_reg[bus.wb_rw] <= bus.wb_data;
    end
  end

  always_comb begin
    rd_a = rf_reg[ra];
    if (ra == '0) rd_a = '0;
    else if (BYPASS != 0 && bus.wb_we && bus.wb_rw == ra) rd_a = bus.wb_data;
    rd_b = rf_reg[rb];
    if (rb == '0) rd_b = '0;
    else if (BYPASS != 0 && bus.wb_we && bus.wb_rw == rb) rd_b = bus.wb_data;
  end

  assign lu = bus.valid_in && bus.ex_valid && bus.ex_memtoreg && bus.ex_rw != '0 &&
              (bus.ex_rw == ra || bus.ex_rw == rb);
  assign accept   = bus.valid_in && !bus.flush_in && !lu && state_reg == RUN;
  assign halt_now = accept && ((syscall && rd_a == XLEN'(SYS_EXIT)) || bus.ins_in == 32'h0);
  assign display  = accept && syscall && rd_a != XLEN'(SYS_EXIT);
  assign bus.stall_out = !rst && ((lu && !bus.flush_in) || state_reg == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;     halt_reg <= 1'b0;
      id_valid_reg <= 1'b0; id_ctrl_reg <= '0;
      a_reg <= '0; b_reg <= '0; ext_reg <= '0; imm_reg <= '0;
      index_reg <= '0; pc_reg <= '0; rw_reg <= '0;
      sys_out_reg <= '0; count_reg <= '0;
    end else begin
      if (accept && !halt_now) begin
        id_valid_reg <= 1'b1;
        id_ctrl_reg  <= ctrl;
        a_reg        <= rd_a;
        b_reg        <= rd_b;
        ext_reg      <= XLEN'(ext32);
        imm_reg      <= XLEN'({bus.ins_in[15:0], 16'h0});
        index_reg    <= XLEN'(bus.ins_in[25:0]);
        pc_reg       <= bus.pc_in;
        rw_reg       <= rw;
      end else begin
        id_valid_reg <= 1'b0;
        id_ctrl_reg  <= '0;
      end
      if (halt_now) begin
        state_reg <= HALTED;
        halt_reg  <= 1'b1;
      end
      if (display) begin
        sys_out_reg <= rd_b;
        if (count_reg != {CNT_W{1'b1}}) count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign bus.id_valid      = id_valid_reg;
  assign bus.id_ctrl       = id_ctrl_reg;
  assign bus.id_A          = a_reg;
  assign bus.id_B          = b_reg;
  assign bus.id_ext        = ext_reg;
  assign bus.id_imm        = imm_reg;
  assign bus.id_index      = index_reg;
  assign bus.id_pc         = pc_reg;
  assign bus.id_rw         = rw_reg;
  assign bus.syscall_out   = sys_out_reg;
  assign bus.syscall_count = count_reg;
  assign bus.halt          = halt_reg;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: table-driven instruction model, random plus directed stimulus.
module tb_id_stage_pipe;
  localparam int XLEN = 32, NREG = 32, CNT_W = 8, SYS_EXIT = 10;
  localparam int K_ADD = 0, K_SLL = 8, K_SYS = 12, K_ADDI = 13, NKIND = 28;
  localparam logic [12:0] F_JR = 13'h1000, F_JAL = 13'h0800, F_J = 13'h0400,
    F_BNE = 13'h0200, F_BEQ = 13'h0100, F_BLEZ = 13'h0080, F_MW = 13'h0040,
    F_MTR = 13'h0020, F_RW = 13'h0010, F_AS = 13'h0008, F_RD = 13'h0004,
    F_LB = 13'h0002, F_LUI = 13'h0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) bus ();
  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1), .SYS_EXIT(SYS_EXIT), .CNT_W(CNT_W))
    u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // e: extender mode 0 = zero imm16, 1 = sign imm16, 2 = shamt
  typedef struct packed {logic [5:0] op; logic [5:0] funct; logic [3:0] aluop;
                         logic [12:0] flg; logic [1:0] e; logic rtype;} kind_t;
  typedef struct packed {logic [16:0] ctrl; logic [31:0] a, b, ext, imm, index, pc;
                         logic [4:0] rw;} idex_t;
  typedef struct packed {logic halt; logic [31:0] sys_out; logic [CNT_W-1:0] cnt;
                         logic valid;} stat_t;

  idex_t idex_q[$];
  stat_t stat_q[$];
  int checks = 0, errors = 0;

  logic [31:0]      m_regs [32];
  bit               m_halted;
  logic [31:0]      m_sys;
  logic [CNT_W-1:0] m_cnt;

  function automatic kind_t kind_of(int k);
    case (k)
      0:  return '{6'h00, 6'h20, 4'd0,  F_RW | F_RD, 2'd0, 1'b1};
      1:  return '{6'h00, 6'h22, 4'd1,  F_RW | F_RD, 2'd0, 1'b1};
      2:  return '{6'h00, 6'h24, 4'd2,  F_RW | F_RD, 2'd0, 1'b1};
      3:  return '{6'h00, 6'h25, 4'd3,  F_RW | F_RD, 2'd0, 1'b1};
      4:  return '{6'h00, 6'h26, 4'd4,  F_RW | F_RD, 2'd0, 1'b1};
      5:  return '{6'h00, 6'h27, 4'd5,  F_RW | F_RD, 2'd0, 1'b1};
      6:  return '{6'h00, 6'h2A, 4'd6,  F_RW | F_RD, 2'd0, 1'b1};
      7:  return '{6'h00, 6'h2B, 4'd7,  F_RW | F_RD, 2'd0, 1'b1};
      8:  return '{6'h00, 6'h00, 4'd8,  F_RW | F_RD | F_AS, 2'd2, 1'b1};
      9:  return '{6'h00, 6'h02, 4'd9,  F_RW | F_RD | F_AS, 2'd2, 1'b1};
      10: return '{6'h00, 6'h03, 4'd10, F_RW | F_RD | F_AS, 2'd2, 1'b1};
      11: return '{6'h00, 6'h08, 4'd0,  F_JR, 2'd0, 1'b1};
      12: return '{6'h00, 6'h0C, 4'd0,  13'h0, 2'd0, 1'b1};
      13: return '{6'h08, 6'h00, 4'd0,  F_RW | F_AS, 2'd1, 1'b0};
      14: return '{6'h0C, 6'h00, 4'd2,  F_RW | F_AS, 2'd0, 1'b0};
      15: return '{6'h0D, 6'h00, 4'd3,  F_RW | F_AS, 2'd0, 1'b0};
      16: return '{6'h0E, 6'h00, 4'd4,  F_RW | F_AS, 2'd0, 1'b0};
      17: return '{6'h0A, 6'h00, 4'd6,  F_RW | F_AS, 2'd1, 1'b0};
      18: return '{6'h0B, 6'h00, 4'd7,  F_RW | F_AS, 2'd1, 1'b0};
      19: return '{6'h0F, 6'h00, 4'd0,  F_RW | F_LUI, 2'd0, 1'b0};
      20: return '{6'h23, 6'h00, 4'd0,  F_RW | F_AS | F_MTR, 2'd1, 1'b0};
      21: return '{6'h20, 6'h00, 4'd0,  F_RW | F_AS | F_MTR | F_LB, 2'd1, 1'b0};
      22: return '{6'h2B, 6'h00, 4'd0,  F_AS | F_MW, 2'd1, 1'b0};
      23: return '{6'h04, 6'h00, 4'd1,  F_BEQ, 2'd1, 1'b0};
      24: return '{6'h05, 6'h00, 4'd1,  F_BNE, 2'd1, 1'b0};
      25: return '{6'h06, 6'h00, 4'd1,  F_BLEZ, 2'd1, 1'b0};
      26: return '{6'h02, 6'h00, 4'd0,  F_J, 2'd0, 1'b0};
      default: return '{6'h03, 6'h00, 4'd0, F_JAL | F_RW, 2'd0, 1'b0};
    endcase
  endfunction

  function automatic logic [25:0] mk_i(logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {rs, rt, imm};
  endfunction

  function automatic logic [25:0] mk_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh);
    return {rs, rt, rd, sh, 6'h0};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural register read as seen by the decode stage (WB write visible same cycle).
  function automatic logic [31:0] rd_val(logic [4:0] r, bit we, logic [4:0] wrw, logic [31:0] wdata);
    if (r == 5'd0) return 32'h0;
    if (we && wrw == r) return wdata;
    return m_regs[r];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.ins_in = 32'h0; bus.pc_in = '0; bus.valid_in = 1'b0; bus.flush_in = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_memtoreg = 1'b0; bus.ex_rw = '0;
    bus.wb_we = 1'b0; bus.wb_rw = '0; bus.wb_data = '0;
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_halted = 1'b0; m_sys = 32'h0; m_cnt = '0;
    stat_q.push_back('{1'b0, 32'h0, {CNT_W{1'b0}}, 1'b0});
    #1 chk("stall_in_reset", bus.stall_out, 1'b0);
    @(negedge clk);
  endtask

  task automatic step(int k, logic [25:0] f26, bit valid, bit flush, bit exv, bit exm,
                      logic [4:0] exrw, bit we, logic [4:0] wrw, logic [31:0] wdata);
    kind_t t = kind_of(k);
    logic [31:0] ins, pc, a, b, ext;
    logic [4:0] rs, rt, rd, r_a, r_b, rw;
    bit sys, lu, accept, halt_now, exp_stall;
    ins = {t.op, f26};
    if (t.rtype) ins[5:0] = t.funct;
    pc = $urandom;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sys = (k == K_SYS);
    r_a = sys ? 5'd2 : (t.e == 2'd2 ? rt : rs);
    r_b = sys ? 5'd4 : rt;
    a = rd_val(r_a, we, wrw, wdata);
    b = rd_val(r_b, we, wrw, wdata);
    lu = valid && exv && exm && exrw != 0 && (exrw == r_a || exrw == r_b);
    exp_stall = (lu && !flush) || m_halted;
    accept = valid && !flush && !lu && !m_halted;
    halt_now = accept && ((sys && a == SYS_EXIT) || ins == 32'h0);
    case (t.e)
      2'd1:    ext = {{16{ins[15]}}, ins[15:0]};
      2'd2:    ext = {27'h0, ins[10:6]};
      default: ext = {16'h0, ins[15:0]};
    endcase
    rw = (t.flg & F_JAL) != 0 ? 5'd31 : ((t.flg & F_RD) != 0 ? rd : rt);
    if (accept && !halt_now)
      idex_q.push_back('{{t.aluop, t.flg}, a, b, ext, {ins[15:0], 16'h0}, {6'h0, ins[25:0]}, pc, rw});
    if (accept && sys && a != SYS_EXIT) begin
      m_sys = b;
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    if (halt_now) m_halted = 1'b1;
    if (we && wrw != 0) m_regs[wrw] = wdata;
    stat_q.push_back('{m_halted, m_sys, m_cnt, accept && !halt_now});

    rst = 1'b0;
    bus.ins_in = ins; bus.pc_in = pc; bus.valid_in = valid; bus.flush_in = flush;
    bus.ex_valid = exv; bus.ex_memtoreg = exm; bus.ex_rw = exrw;
    bus.wb_we = we; bus.wb_rw = wrw; bus.wb_data = wdata;
    #1 chk("stall_out", bus.stall_out, exp_stall);
    @(negedge clk);
  endtask

  // Monitor: one status record per edge, one ID/EX record per valid output.
  initial begin
    stat_t s;
    idex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("halt", bus.halt, s.halt);
        chk("syscall_out", bus.syscall_out, s.sys_out);
        chk("syscall_count", bus.syscall_count, s.cnt);
        chk("id_valid", bus.id_valid, s.valid);
        if (bus.id_valid === 1'b1) begin
          if (idex_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL idex_unexpected: id_valid=1 with no expected entry, pc=%0h", bus.id_pc);
          end else begin
            e = idex_q.pop_front();
            chk("id_ctrl", bus.id_ctrl, e.ctrl);
            chk("id_A", bus.id_A, e.a);
            chk("id_B", bus.id_B, e.b);
            chk("id_ext", bus.id_ext, e.ext);
            chk("id_imm", bus.id_imm, e.imm);
            chk("id_index", bus.id_index, e.index);
            chk("id_pc", bus.id_pc, e.pc);
            chk("id_rw", bus.id_rw, e.rw);
            $display("idex pc=%08h ctrl=%05h A=%08h B=%08h ext=%08h rw=%0d",
                     bus.id_pc, bus.id_ctrl, bus.id_A, bus.id_B, bus.id_ext, bus.id_rw);
          end
        end
      end
    end
  end

  initial begin
    int k;
    logic [25:0] f;
    logic [4:0] wrw;
    logic [31:0] wd;
    rst = 1'b1;
    bus.ins_in = 32'h0; bus.pc_in = '0; bus.valid_in = 1'b0; bus.flush_in = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_memtoreg = 1'b0; bus.ex_rw = '0;
    bus.wb_we = 1'b0; bus.wb_rw = '0; bus.wb_data = '0;
    @(negedge clk);
    do_reset();

    step(K_ADDI, mk_i(5'd0, 5'd1, 16'd5), 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step(K_ADD, mk_r(5'd3, 5'd3, 5'd4, 5'd0), 1, 0, 0, 0, 5'd0, 1, 5'd3, 32'hDEAD);
    // load-use on $8, then the stall clears and the same instruction is accepted
    step(K_ADD, mk_r(5'd8, 5'd0, 5'd9, 5'd0), 1, 0, 1, 1, 5'd8, 0, 5'd0, 32'h0);
    step(K_ADD, mk_r(5'd8, 5'd0, 5'd9, 5'd0), 1, 0, 1, 1, 5'd8, 0, 5'd0, 32'h0);
    step(K_ADD, mk_r(5'd8, 5'd0, 5'd9, 5'd0), 1, 0, 0, 0, 5'd0, 1, 5'd8, 32'h55);
    step(K_ADD, 26'h0, 0, 0, 0, 0, 5'd0, 1, 5'd2, 32'd1);
    step(K_ADD, 26'h0, 0, 0, 0, 0, 5'd0, 1, 5'd4, 32'h1234);
    step(K_SYS, 26'h0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step(K_SYS, 26'h0, 1, 0, 1, 1, 5'd4, 0, 5'd0, 32'h0);
    step(K_SYS, 26'h0, 1, 0, 1, 1, 5'd4, 0, 5'd0, 32'h0);
    step(K_SYS, 26'h0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);

    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(NKIND - 1);
      f = 26'($urandom);
      f[25:23] = 3'b0; f[20:18] = 3'b0;
      if (k == K_SLL && f == 26'h0) f = 26'h1;
      wrw = 5'($urandom_range(7));
      wd = $urandom;
      if (wrw == 5'd2 && wd == SYS_EXIT) wd = wd + 1;
      step(k, f, ($urandom_range(9) < 8), ($urandom_range(9) == 0),
           $urandom_range(1), $urandom_range(1), 5'($urandom_range(7)),
           $urandom_range(1), wrw, wd);
    end

    step(K_ADD, 26'h0, 0, 0, 0, 0, 5'd0, 1, 5'd2, 32'd1);
    step(K_ADD, 26'h0, 0, 0, 0, 0, 5'd0, 1, 5'd4, 32'hCAFE);
    for (int n = 0; n < 300; n++)
      step(K_SYS, 26'($urandom), 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);

    // exit syscall halts; later instructions stay stalled until reset
    step(K_ADD, 26'h0, 0, 0, 0, 0, 5'd0, 1, 5'd2, 32'd10);
    step(K_SYS, 26'h0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    for (int n = 0; n < 4; n++)
      step(K_ADDI, mk_i(5'd0, 5'd1, 16'($urandom)), 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    do_reset();
    step(K_SLL, 26'h0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step(K_ADDI, mk_i(5'd0, 5'd1, 16'd7), 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    do_reset();
    step(K_ADD, mk_r(5'd5, 5'd6, 5'd7, 5'd0), 1, 0, 1, 1, 5'd6, 0, 5'd0, 32'h0);
    do_reset();
    step(K_ADDI, mk_i(5'd0, 5'd3, 16'hFFFF), 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step(K_ADD, 26'h0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);

    @(posedge clk);
    #2;
    chk("idex_q_drained", idex_q.size(), 0);
    chk("stat_q_drained", stat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
